csr_std_rd: RTL and testbench

//  Read side of the standard CSR block: accepts CSR read requests from the EXE stage and returns the selected
//  CSR value or an illegal-access flag. Sources are the csr_name outputs of the csr_std_wr instances, flattened.
//  Two-stage pipeline (decode/select, response register) with valid/ready on both ends; one read per cycle.

---
 rtl/cpu_params_pkg.sv | 24 ++
 rtl/csr_addr_match.sv | 29 ++
 rtl/csr_std_rd.sv | 101 ++++++++++
 tb/tb_csr_std_rd.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_params_pkg.sv
// Shared CPU parameters for the CSR read path.
//   RSZ         : register / CSR width
//   CSR_ADDR_W  : CSR address width (12)
//   PRIV_*      : privilege mode encodings (U=0, S=1, M=3; 2 is reserved)
//   csr_req_t   : request fields held in the decode/select stage
//   is_ro_space : addr[11:10]==2'b11 marks the read-only CSR space
package cpu_params_pkg;
   localparam int RSZ        = 32;
   localparam int CSR_ADDR_W = 12;

   localparam logic [1:0] PRIV_U = 2'd0;
   localparam logic [1:0] PRIV_S = 2'd1;
   localparam logic [1:0] PRIV_M = 2'd3;

   typedef struct packed {
      logic [CSR_ADDR_W-1:0] addr;
      logic [1:0]            mode;
      logic                  wr_intent;
   } csr_req_t;

   function automatic logic is_ro_space(input logic [CSR_ADDR_W-1:0] addr);
      return (addr[11:10] == 2'b11);
   endfunction
endpackage

// File: rtl/csr_addr_match.sv
// Combinational CSR address decoder.
//   addr : CSR address to look up
//   hit  : some table entry matches addr
//   sel  : one-hot select of the matching entry; on duplicate entries
//          only the lowest index is selected
module csr_addr_match
   import cpu_params_pkg::*;
#(
   parameter int                            N_CSR      = 8,
   parameter logic [N_CSR*CSR_ADDR_W-1:0]   ADDR_TABLE = '0
) (
   input  logic [CSR_ADDR_W-1:0] addr,
   output logic                  hit,
   output logic [N_CSR-1:0]      sel
);

   // Scan upward; once an entry hits, later duplicates are ignored.
   always_comb begin
      hit = 1'b0;
      sel = '0;
      for (int i = 0; i < N_CSR; i++) begin
         if (!hit && (ADDR_TABLE[i*CSR_ADDR_W +: CSR_ADDR_W] == addr)) begin
            sel[i] = 1'b1;
            hit    = 1'b1;
         end
      end
   end

endmodule

// File: rtl/csr_std_rd.sv
// Read side of the standard CSR block. Requests from EXE pass through a
// decode/select stage (s1) and a response register (rsp). csr_values is
// sampled when s1 moves into rsp, so a write landing on that same edge is
// not seen and the old value is returned.
//
// Handshakes: a transfer happens at a posedge where valid & ready are both 1.
// A producer holds valid and its payload stable until the transfer; ready
// never depends combinationally on the valid/payload of the same interface.
//
// Ports:
//   clk_in, reset_in          : clock, synchronous active-high reset
//   req_valid/req_ready       : request handshake
//   req_addr/mode/wr_intent   : CSR address, privilege mode, write intent
//   csr_values                : flattened CSR contents, CSR i at [i*SZ +: SZ]
//   rsp_valid/rsp_ready       : response handshake
//   rsp_data/rsp_illegal      : CSR value (0 when illegal), illegal flag
module csr_std_rd
   import cpu_params_pkg::*;
#(
   parameter int                            SZ         = RSZ,
   parameter int                            N_CSR      = 8,
   parameter logic [N_CSR*CSR_ADDR_W-1:0]   ADDR_TABLE = '0
) (
   input  logic                  clk_in,
   input  logic                  reset_in,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic [CSR_ADDR_W-1:0] req_addr,
   input  logic [1:0]            req_mode,
   input  logic                  req_wr_intent,
   input  logic [N_CSR*SZ-1:0]   csr_values,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [SZ-1:0]         rsp_data,
   output logic                  rsp_illegal
);

   logic            s1_valid;
   csr_req_t        s1_req;
   logic            s1_advance;
   logic            req_accept;
   logic            hit;
   logic [N_CSR-1:0] sel;
   logic            illegal;
   logic [SZ-1:0]   data_mux;

   csr_addr_match #(
      .N_CSR      (N_CSR),
      .ADDR_TABLE (ADDR_TABLE)
   ) u_match (
      .addr (s1_req.addr),
      .hit  (hit),
      .sel  (sel)
   );

   assign s1_advance = s1_valid & (~rsp_valid | rsp_ready);
   // Gated by reset so nothing is accepted on a reset edge.
   assign req_ready  = ~reset_in & (~s1_valid | s1_advance);
   assign req_accept = req_valid & req_ready;

   // Unsigned 2-bit mode compare; reserved mode 2 ranks between S and M.
   assign illegal = ~hit
                  | (s1_req.mode < s1_req.addr[9:8])
                  | (s1_req.wr_intent & is_ro_space(s1_req.addr));

   // AND-OR mux over the one-hot select.
   always_comb begin
      data_mux = '0;
      for (int i = 0; i < N_CSR; i++) begin
         data_mux = data_mux | (csr_values[i*SZ +: SZ] & {SZ{sel[i]}});
      end
   end

   always_ff @(posedge clk_in) begin
      if (reset_in) begin
         s1_valid    <= 1'b0;
         s1_req      <= '0;
         rsp_valid   <= 1'b0;
         rsp_data    <= '0;
         rsp_illegal <= 1'b0;
      end else begin
         if (req_accept) begin
            s1_valid         <= 1'b1;
            s1_req.addr      <= req_addr;
            s1_req.mode      <= req_mode;
            s1_req.wr_intent <= req_wr_intent;
         end else if (s1_advance) begin
            s1_valid <= 1'b0;
         end

         if (s1_advance) begin
            rsp_valid   <= 1'b1;
            rsp_data    <= illegal ? '0 : data_mux;
            rsp_illegal <= illegal;
         end else if (rsp_ready) begin
            rsp_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_csr_std_rd.sv
// Bench for csr_std_rd: directed scenarios plus randomized traffic, all
// checked every cycle against an in-order transaction model.
module tb_csr_std_rd;
  import cpu_params_pkg::*;

  localparam int SZ    = RSZ;
  localparam int N_CSR = 5;
  localparam logic [N_CSR*12-1:0] TABLE_P = {12'h180, 12'h341, 12'hC00, 12'h341, 12'h300};

  logic                clk_in = 1'b0;
  logic                reset_in = 1'b1;
  logic                req_valid = 1'b0;
  logic                req_ready;
  logic [11:0]         req_addr = '0;
  logic [1:0]          req_mode = '0;
  logic                req_wr_intent = 1'b0;
  logic [N_CSR*SZ-1:0] csr_values = '0;
  logic                rsp_valid;
  logic                rsp_ready = 1'b0;
  logic [SZ-1:0]       rsp_data;
  logic                rsp_illegal;

  csr_std_rd #(.SZ(SZ), .N_CSR(N_CSR), .ADDR_TABLE(TABLE_P)) dut (
    .clk_in(clk_in), .reset_in(reset_in),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_mode(req_mode), .req_wr_intent(req_wr_intent),
    .csr_values(csr_values),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_illegal(rsp_illegal)
  );

  // ---------------- clock ----------------
  always #5 clk_in = ~clk_in;

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [11:0]   addr;
    logic [1:0]    mode;
    logic          wr;
    int            acc;
    bit            known;
    logic [SZ-1:0] data;
    logic          ill;
  } item_t;

  item_t exp_q[$];
  logic [SZ:0] rsp_log[$];   // {illegal, data} of every consumed response

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference lookup straight from the access rules.
  task automatic ref_rd(input logic [11:0] a, input logic [1:0] m, input logic w,
                        input logic [N_CSR*SZ-1:0] vals,
                        output logic [SZ-1:0] d, output logic il);
    logic [11:0] tbl [N_CSR];
    int idx;
    tbl = '{12'h300, 12'h341, 12'hC00, 12'h341, 12'h180};
    idx = -1;
    for (int i = N_CSR - 1; i >= 0; i--) if (tbl[i] == a) idx = i;
    il = (idx < 0) || (int'(m) < int'(a[9:8])) || (w && a[11:10] == 2'b11);
    d  = il ? '0 : vals[idx*SZ +: SZ];
  endtask

  logic                rst_pre = 1'b1;
  logic                qv_pre = 1'b0, qr_pre = 1'b0, rv_pre = 1'b0, rr_pre = 1'b0;
  logic [11:0]         a_pre = '0;
  logic [1:0]          m_pre = '0;
  logic                w_pre = 1'b0;
  logic [N_CSR*SZ-1:0] vals_pre = '0;
  int                  edge_n = 0;

  // Compare process: at each negedge apply the previous posedge to the model,
  // then check the DUT, then record what the next posedge will sample.
  always @(negedge clk_in) begin
    item_t h;
    logic [SZ-1:0] d;
    logic il;
    bit exp_rv;
    edge_n++;
    if (rst_pre) begin
      exp_q.delete();
    end else begin
      if (rv_pre && rr_pre && exp_q.size() > 0) void'(exp_q.pop_front());
      if (qv_pre && qr_pre)
        exp_q.push_back('{addr: a_pre, mode: m_pre, wr: w_pre, acc: edge_n, known: 1'b0, data: '0, ill: 1'b0});
      if (exp_q.size() > 0 && exp_q[0].acc < edge_n && !exp_q[0].known) begin
        h = exp_q[0];
        ref_rd(h.addr, h.mode, h.wr, vals_pre, d, il);
        h.data = d; h.ill = il; h.known = 1'b1;
        exp_q[0] = h;
      end
    end
    exp_rv = (exp_q.size() > 0) && (exp_q[0].acc < edge_n);
    chk("req_ready", 64'(req_ready), 64'(!reset_in && (exp_q.size() < 2 || rsp_ready)));
    chk("rsp_valid", 64'(rsp_valid), 64'(exp_rv));
    if (exp_rv) begin
      chk("rsp_data", 64'(rsp_data), 64'(exp_q[0].data));
      chk("rsp_illegal", 64'(rsp_illegal), 64'(exp_q[0].ill));
    end
    if (rsp_valid && rsp_ready && !reset_in) rsp_log.push_back({rsp_illegal, rsp_data});
    rst_pre = reset_in;
    qv_pre = req_valid; qr_pre = req_ready;
    rv_pre = rsp_valid; rr_pre = rsp_ready;
    a_pre = req_addr; m_pre = req_mode; w_pre = req_wr_intent;
    vals_pre = csr_values;
  end

  // ---------------- driver tasks (called at posedge+1) ----------------
  task automatic set_csr(input int i, input logic [SZ-1:0] v);
    csr_values[i*SZ +: SZ] = v;
  endtask

  task automatic send(input logic [11:0] a, input logic [1:0] m, input logic w, output int waits);
    logic acc;
    req_valid = 1'b1; req_addr = a; req_mode = m; req_wr_intent = w;
    waits = 0;
    forever begin
      @(negedge clk_in); acc = req_ready;
      @(posedge clk_in); #1;
      if (acc) break;
      waits++;
      if (waits > 60) begin
        n_checks++; n_fail++;
        $display("FAIL send_timeout: addr %0h not accepted, required acceptance within 60 cycles", a);
        break;
      end
    end
    req_valid = 1'b0;
  endtask

  task automatic wait_log(input int n);
    int t;
    t = 0;
    do begin @(posedge clk_in); t++; end while (rsp_log.size() < n && t < 100);
    #1;
    if (rsp_log.size() < n) begin
      n_checks++; n_fail++;
      $display("FAIL rsp_timeout: got %0d responses required %0d", rsp_log.size(), n);
    end
  endtask

  task automatic rd1(input string name, input logic [11:0] a, input logic [1:0] m, input logic w,
                     input logic [SZ-1:0] ed, input logic eil);
    int base, wt;
    base = rsp_log.size();
    send(a, m, w, wt);
    wait_log(base + 1);
    if (rsp_log.size() > base) begin
      chk({name, "_data"}, 64'(rsp_log[base][SZ-1:0]), 64'(ed));
      chk({name, "_ill"},  64'(rsp_log[base][SZ]),     64'(eil));
    end
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #300000;
    n_checks++; n_fail++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // ---------------- stimulus ----------------
  initial begin
    int wt, base;
    logic [SZ-1:0] d0;
    set_csr(0, 32'h1800);
    set_csr(1, 32'h80);
    set_csr(2, 32'h1234_5678);
    set_csr(3, 32'hDEAD);
    set_csr(4, 32'h22);
    repeat (3) @(posedge clk_in);
    #1;
    chk("rst_valid", 64'(rsp_valid), 64'd0);
    chk("rst_data", 64'(rsp_data), 64'd0);
    chk("rst_ill", 64'(rsp_illegal), 64'd0);
    chk("rst_req_ready", 64'(req_ready), 64'd0);
    reset_in = 1'b0;
    rsp_ready = 1'b1;

    // 1) M-mode read of 0x341, rsp_valid one cycle after the accept edge
    base = rsp_log.size();
    send(12'h341, PRIV_M, 1'b0, wt);
    chk("t1_first_accept_waits", 64'(wt), 64'd0);
    @(negedge clk_in); chk("t1_lat_s1", 64'(rsp_valid), 64'd0);
    @(negedge clk_in); chk("t1_lat_rsp", 64'(rsp_valid), 64'd1);
    wait_log(base + 1);
    if (rsp_log.size() > base) chk("t1_data", 64'(rsp_log[base]), 64'h80);

    // 2) privilege checks
    rd1("t2_u_300", 12'h300, PRIV_U, 1'b0, 32'h0, 1'b1);
    rd1("t2_m_300", 12'h300, PRIV_M, 1'b0, 32'h1800, 1'b0);
    rd1("t2_r2_300", 12'h300, 2'd2, 1'b0, 32'h0, 1'b1);
    rd1("t2_r2_180", 12'h180, 2'd2, 1'b0, 32'h22, 1'b0);
    rd1("t2_u_180", 12'h180, PRIV_U, 1'b0, 32'h0, 1'b1);
    rd1("t2_s_180", 12'h180, PRIV_S, 1'b0, 32'h22, 1'b0);

    // 3) unmapped address and read-only space
    rd1("t3_7c0", 12'h7C0, PRIV_M, 1'b0, 32'h0, 1'b1);
    rd1("t3_c00_wr", 12'hC00, PRIV_U, 1'b1, 32'h0, 1'b1);
    rd1("t3_c00_rd", 12'hC00, PRIV_U, 1'b0, 32'h1234_5678, 1'b0);
    rd1("t3_341_wr", 12'h341, PRIV_M, 1'b1, 32'h80, 1'b0);  // duplicate: index 1 wins

    // 4) four back-to-back reads under backpressure
    base = rsp_log.size();
    rsp_ready = 1'b0;
    fork
      begin
        send(12'h300, PRIV_M, 1'b0, wt);
        send(12'h341, PRIV_M, 1'b0, wt);
        send(12'h180, PRIV_M, 1'b0, wt);
        send(12'hC00, PRIV_M, 1'b0, wt);
      end
      begin
        repeat (2) @(posedge clk_in);
        @(negedge clk_in);
        chk("t4_full_req_ready", 64'(req_ready), 64'd0);
        d0 = rsp_data;
        @(negedge clk_in);
        chk("t4_hold_data", 64'(rsp_data), 64'(d0));
        chk("t4_hold_valid", 64'(rsp_valid), 64'd1);
        @(posedge clk_in); #1;
        rsp_ready = 1'b1;
      end
    join
    wait_log(base + 4);
    if (rsp_log.size() >= base + 4) begin
      chk("t4_r0", 64'(rsp_log[base]),   64'h1800);
      chk("t4_r1", 64'(rsp_log[base+1]), 64'h80);
      chk("t4_r2", 64'(rsp_log[base+2]), 64'h22);
      chk("t4_r3", 64'(rsp_log[base+3]), 64'h1234_5678);
    end

    // 5) CSR write on the transfer edge is not visible
    base = rsp_log.size();
    send(12'h341, PRIV_M, 1'b0, wt);
    @(posedge clk_in); #1;
    set_csr(1, 32'h81);
    wait_log(base + 1);
    if (rsp_log.size() > base) chk("t5_old", 64'(rsp_log[base]), 64'h80);
    rd1("t5_new", 12'h341, PRIV_M, 1'b0, 32'h81, 1'b0);

    // 6) reset with s1 and rsp both full
    rsp_ready = 1'b0;
    send(12'h300, PRIV_M, 1'b0, wt);
    send(12'h341, PRIV_M, 1'b0, wt);
    base = rsp_log.size();
    reset_in = 1'b1;
    req_valid = 1'b1; req_addr = 12'h180; req_mode = PRIV_M; req_wr_intent = 1'b0;
    @(negedge clk_in); chk("t6_rst_req_ready", 64'(req_ready), 64'd0);
    @(posedge clk_in); #1;
    reset_in = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk_in);
    chk("t6_no_stale", 64'(rsp_valid), 64'd0);
    chk("t6_ready_after", 64'(req_ready), 64'd1);
    @(posedge clk_in); #1;
    req_valid = 1'b0;
    wait_log(base + 1);
    chk("t6_count", 64'(rsp_log.size()), 64'(base + 1));
    if (rsp_log.size() > base) chk("t6_new", 64'(rsp_log[base]), 64'h22);

    // 7) randomized traffic
    for (int c = 0; c < 500; c++) begin
      logic acc;
      @(negedge clk_in); acc = req_valid & req_ready;
      @(posedge clk_in); #1;
      if (!req_valid || acc) begin
        req_valid = ($urandom_range(0, 3) != 0);
        case ($urandom_range(0, 6))
          0: req_addr = 12'h300;
          1: req_addr = 12'h341;
          2: req_addr = 12'hC00;
          3: req_addr = 12'h180;
          4: req_addr = 12'h7C0;
          5: req_addr = 12'hC01;
          default: req_addr = 12'($urandom_range(0, 4095));
        endcase
        req_mode = 2'($urandom_range(0, 3));
        req_wr_intent = 1'($urandom_range(0, 1));
      end
      rsp_ready = ($urandom_range(0, 2) != 0);
      if ($urandom_range(0, 3) == 0) set_csr(int'($urandom_range(0, N_CSR - 1)), SZ'($urandom));
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    repeat (6) @(posedge clk_in);
    #1;
    chk("drain_empty", 64'(rsp_valid), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
